// File: rtl/dm_param.sv
// dm_param: parametrised single-port data memory with post-reset clear/seed.
// Optional macro DM_SOFT_CLEAR_EN adds a synchronous soft_clr input.
module dm_param #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 3,
  parameter int DEPTH     = 8,
  parameter int INIT_ADDR = 1,
  parameter int INIT_VAL  = 6
) (
`ifdef DM_SOFT_CLEAR_EN
  input  logic                    soft_clr,
`endif
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic                    busy,
  output logic [DEPTH*DATA_W-1:0] dump
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_IDLE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                in_range;
  logic                accept;
  logic                soft_go;
  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [DATA_W-1:0]   wdata;

`ifdef DM_SOFT_CLEAR_EN
  assign soft_go = soft_clr;
`else
  assign soft_go = 1'b0;
`endif

  assign in_range  = 32'(req_addr) < DEPTH;
  assign busy      = (state_q == S_CLEAR);
  assign req_ready = (state_q == S_IDLE) & (~rsp_valid_q | rsp_ready);
  assign accept    = req_valid & req_ready;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Sequencer: clear/seed walk, then serve requests; picks the array write.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    we      = 1'b0;
    waddr   = req_addr;
    wdata   = req_wdata;
    unique case (state_q)
      S_CLEAR: begin
        we    = 1'b1;
        waddr = ptr_q;
        wdata = (32'(ptr_q) == INIT_ADDR) ? DATA_W'(INIT_VAL) : '0;
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST) begin
          state_d = S_IDLE;
          ptr_d   = '0;
        end
      end
      S_IDLE: begin
        we = accept & req_write & in_range;
        if (soft_go & ~accept) begin
          state_d = S_CLEAR;
          ptr_d   = '0;
        end
      end
    endcase
  end

  // Response register: load on accept, drop when consumed, else hold.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = in_range ? mem_q[req_addr] : '0;
      rsp_err_d   = ~in_range;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Control and response state, cleared by async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_CLEAR;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Storage array; contents survive reset and are zeroed by the sequencer.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Flattened debug view, entry 0 in the MSBs.
  always_comb begin
    dump = '0;
    for (int i = 0; i < DEPTH; i++)
      dump[(DEPTH-1-i)*DATA_W +: DATA_W] = mem_q[i];
  end

endmodule

// File: tb/tb_dm_param.sv
// tb_dm_param: scoreboard bench for dm_param (DEPTH=8 and DEPTH=6 copies).
// Expected responses are queued at accept and popped by per-DUT monitors.
module tb_dm_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
`ifdef DM_SOFT_CLEAR_EN
  logic soft_clr;
`endif

  logic        v8, rdy8, w8, rv8, rr8, re8, busy8;
  logic [2:0]  a8;
  logic [7:0]  wd8, rd8;
  logic [63:0] dump8;

  logic        v6, rdy6, w6, rv6, rr6, re6, busy6;
  logic [2:0]  a6;
  logic [7:0]  wd6, rd6;
  logic [47:0] dump6;

  dm_param u8 (
`ifdef DM_SOFT_CLEAR_EN
    .soft_clr  (soft_clr),
`endif
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (v8),
    .req_ready (rdy8),
    .req_write (w8),
    .req_addr  (a8),
    .req_wdata (wd8),
    .rsp_valid (rv8),
    .rsp_ready (rr8),
    .rsp_rdata (rd8),
    .rsp_err   (re8),
    .busy      (busy8),
    .dump      (dump8)
  );

  dm_param #(.DEPTH(6)) u6 (
`ifdef DM_SOFT_CLEAR_EN
    .soft_clr  (1'b0),
`endif
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (v6),
    .req_ready (rdy6),
    .req_write (w6),
    .req_addr  (a6),
    .req_wdata (wd6),
    .rsp_valid (rv6),
    .rsp_ready (rr6),
    .rsp_rdata (rd6),
    .rsp_err   (re6),
    .busy      (busy6),
    .dump      (dump6)
  );

  typedef struct {
    logic [7:0] d;
    logic       e;
    int         acc;
    bit         fast;
  } exp_t;

  exp_t q8[$];
  exp_t q6[$];
  int   vecs = 0;
  int   errs = 0;
  int   cyc  = 0;
  logic [7:0] m8 [8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Monitor for the DEPTH=8 copy.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rv8 && rr8) begin
      if (q8.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL rsp8_unexpected: got %0h, want none", rd8);
      end else begin
        e = q8.pop_front();
        chk("rsp8_data", rd8, e.d);
        chk("rsp8_err", re8, e.e);
        if (e.fast) chk("rsp8_latency", cyc, e.acc + 1);
      end
    end
  end

  // Monitor for the DEPTH=6 copy.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rv6 && rr6) begin
      if (q6.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL rsp6_unexpected: got %0h, want none", rd6);
      end else begin
        e = q6.pop_front();
        chk("rsp6_data", rd6, e.d);
        chk("rsp6_err", re6, e.e);
        if (e.fast) chk("rsp6_latency", cyc, e.acc + 1);
      end
    end
  end

  task automatic send8(input logic w, input logic [2:0] a,
                       input logic [7:0] d, input logic [7:0] ed,
                       input logic ee, input bit fast);
    int   n;
    exp_t e;
    v8 = 1'b1; w8 = w; a8 = a; wd8 = d; n = 0;
    @(negedge clk);
    while (!rdy8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy8) begin
      vecs++; errs++;
      $display("FAIL send8_timeout: got ready=0, want 1");
    end else begin
      e.d = ed; e.e = ee; e.acc = cyc; e.fast = fast;
      q8.push_back(e);
    end
    @(posedge clk); #1;
    v8 = 1'b0;
  endtask

  task automatic send6(input logic w, input logic [2:0] a,
                       input logic [7:0] d, input logic [7:0] ed,
                       input logic ee);
    int   n;
    exp_t e;
    v6 = 1'b1; w6 = w; a6 = a; wd6 = d; n = 0;
    @(negedge clk);
    while (!rdy6 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy6) begin
      vecs++; errs++;
      $display("FAIL send6_timeout: got ready=0, want 1");
    end else begin
      e.d = ed; e.e = ee; e.acc = cyc; e.fast = 1'b1;
      q6.push_back(e);
    end
    @(posedge clk); #1;
    v6 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q8.size() != 0 || q6.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(q8.size() + q6.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_clear8(input string nm);
    int n, bad;
    n = 0; bad = 0;
    while (busy8 && n < 30) begin
      if (rdy8) bad++;
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_cycles"}, n, 8);
    chk({nm, "_ready_low"}, bad, 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m8[i] = 8'h00;
    m8[1] = 8'h06;
  endtask

  initial begin
    int n, n8, n6, bad;
    rst_n = 1'b0;
`ifdef DM_SOFT_CLEAR_EN
    soft_clr = 1'b0;
`endif
    v8 = 0; w8 = 0; a8 = 0; wd8 = 0; rr8 = 1;
    v6 = 0; w6 = 0; a6 = 0; wd6 = 0; rr6 = 1;
    model_reset();

    // Reset state.
    #3;
    chk("rst_busy", busy8, 1'b1);
    chk("rst_req_ready", rdy8, 1'b0);
    chk("rst_rsp_valid", rv8, 1'b0);
    chk("rst_rsp_rdata", rd8, 8'h00);
    chk("rst_rsp_err", re8, 1'b0);

    // 1: clear sequence length and seeded contents.
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n = 0; n8 = 0; n6 = 0; bad = 0;
    while ((busy8 || busy6) && n < 30) begin
      if (busy8 && rdy8) bad++;
      if (busy6 && rdy6) bad++;
      @(posedge clk); #1;
      n++;
      if (!busy8 && n8 == 0) n8 = n;
      if (!busy6 && n6 == 0) n6 = n;
    end
    chk("clear8_cycles", n8, 8);
    chk("clear6_cycles", n6, 6);
    chk("clear_ready_low", bad, 0);
    chk("clear8_dump", dump8, 64'h0006000000000000);
    chk("clear6_dump", dump6, 48'h000600000000);

    // 2: write then read-after-write, read-before-write data.
    send8(1'b1, 3'd5, 8'hA5, 8'h00, 1'b0, 1'b1);
    m8[5] = 8'hA5;
    send8(1'b0, 3'd5, 8'h00, 8'hA5, 1'b0, 1'b1);
    drain();

    // 3: out-of-range on DEPTH=6, then the last valid entry.
    send6(1'b1, 3'd7, 8'hFF, 8'h00, 1'b1);
    send6(1'b0, 3'd7, 8'h00, 8'h00, 1'b1);
    drain();
    chk("oor_dump6", dump6, 48'h000600000000);
    send6(1'b1, 3'd5, 8'h3C, 8'h00, 1'b0);
    send6(1'b0, 3'd5, 8'h00, 8'h3C, 1'b0);
    drain();
    chk("last_dump6", dump6, 48'h00060000003C);

    // 4: stalled response holds; queued request goes on release.
    rr8 = 1'b0;
    send8(1'b0, 3'd1, 8'h00, 8'h06, 1'b0, 1'b0);
    v8 = 1'b1; w8 = 1'b0; a8 = 3'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_valid", rv8, 1'b1);
      chk("hold_rdata", rd8, 8'h06);
      chk("hold_ready", rdy8, 1'b0);
    end
    @(posedge clk); #1 rr8 = 1'b1;
    @(negedge clk);
    chk("release_ready", rdy8, 1'b1);
    if (rdy8) q8.push_back('{d: 8'hA5, e: 1'b0, acc: cyc, fast: 1'b1});
    @(posedge clk); #1 v8 = 1'b0;
    drain();

    // 5: streamed reads of every entry.
    for (int i = 0; i < 8; i++)
      send8(1'b0, 3'(i), 8'h00, m8[i], 1'b0, 1'b1);
    drain();
    chk("stream_dump", dump8, 64'h00060000_00A50000);

    // 6: reset with a response pending, then recovery.
    rr8 = 1'b0;
    send8(1'b0, 3'd2, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("pend_valid", rv8, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", rv8, 1'b0);
    chk("midrst_busy", busy8, 1'b1);
    q8.delete();
    q6.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    rr8 = 1'b1;
    model_reset();
    wait_clear8("reclear");
    chk("reclear_dump", dump8, 64'h0006000000000000);

`ifdef DM_SOFT_CLEAR_EN
    send8(1'b1, 3'd3, 8'h77, 8'h00, 1'b0, 1'b1);
    drain();
    chk("pre_soft_dump", dump8, 64'h0006007700000000);
    soft_clr = 1'b1;
    @(posedge clk); #1;
    chk("soft_busy", busy8, 1'b1);
    soft_clr = 1'b0;
    wait_clear8("softclr");
    chk("softclr_dump", dump8, 64'h0006000000000000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/dm_param.md
Name: dm_param

Overview:
Parametrised single-port data memory, the successor to the fixed 8x8 data memory in the single-cycle datapath.
- Adds configurable width and depth, and a valid/ready request/response handshake with 1-cycle registered read latency.
- Adds a post-reset clear sequencer that zeroes the array and seeds one init word, plus read-before-write response data.
- Keeps a flattened whole-array debug dump for the top-level monitor.

Parameters:
DATA_W, 8, word width in bits
ADDR_W, 3, address width in bits
DEPTH, 8, number of entries (1..2**ADDR_W)
INIT_ADDR, 1, entry seeded after clear
INIT_VAL, 6, value written to INIT_ADDR during clear

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  request accepted when req_valid & req_ready
req_write  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  word address
req_wdata  input  DATA_W  write data
rsp_valid  output  1  response held in output register
rsp_ready  input  1  response consumed when rsp_valid & rsp_ready
rsp_rdata  output  DATA_W  read data; for writes, the previous contents
rsp_err  output  1  request address >= DEPTH
busy  output  1  clear sequence in progress
dump  output  DEPTH*DATA_W  all entries; entry 0 in the MSBs

Behaviour:
- Reset (rst_n low, asynchronous): FSM=CLEAR, clear pointer=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=1. Array contents are not reset asynchronously.
- CLEAR state:
  - Each cycle writes entry[ptr] = (ptr==INIT_ADDR ? INIT_VAL : 0), then ptr++.
  - After writing DEPTH-1: go to IDLE, busy=0. Clear takes exactly DEPTH cycles after rst_n rises.
  - If INIT_ADDR >= DEPTH, no seed is written.
- IDLE state: req_ready = ~rsp_valid | rsp_ready. This is combinational from rsp_ready and allows 1 request per cycle under full throughput. req_ready=0 in CLEAR.
- Accept (cycle N):
  - Read: rsp_rdata = entry[req_addr] registered; rsp_valid=1 in cycle N+1.
  - Write: entry[req_addr] <= req_wdata at edge N. rsp_rdata = old entry value. rsp_valid=1 in N+1.
  - Out of range (req_addr >= DEPTH): no array write, rsp_rdata=0, rsp_err=1. Otherwise rsp_err=0.
- Response hold: while rsp_valid & ~rsp_ready, rsp_valid/rsp_rdata/rsp_err are held stable and no new request is accepted.
- Response drop: rsp_valid drops on the edge where it is consumed, unless a new request is accepted on that same edge, in which case it stays high with the new data.
- Back-to-back same address: a read accepted the cycle after a write to that address returns the new data; no bypass is needed with 1-cycle latency.
- dump: combinational from the array. It reflects writes from the edge after they occur, including during CLEAR.
- Reset mid-transaction: an in-flight response is discarded (rsp_valid=0 immediately) and the clear sequence restarts.

Optional Feature:
Macro DM_SOFT_CLEAR_EN.
- Defined: adds input port soft_clr (1 bit, synchronous, active-high).
  - When soft_clr=1 in IDLE and no request is accepted that cycle: enter CLEAR on the next edge, ptr=0, busy=1. The full DEPTH-cycle clear/seed sequence reruns.
  - A pending response register is kept and still drains via rsp_ready.
  - soft_clr is ignored while already in CLEAR.
  - If soft_clr and a request accept coincide, the request wins; soft_clr must be held to take effect.
- Not defined: no soft_clr port; CLEAR is entered only by reset.

Test Plan:
1. Release rst_n, hold rsp_ready=1 -> busy=1, req_ready=0 for exactly 8 cycles, then busy=0; dump = 64'h0006000000000000.
2. Write addr 5 data 8'hA5, then read addr 5 on the next cycle -> first response rsp_rdata=8'h00 (old value), second rsp_rdata=8'hA5; each rsp_valid 1 cycle after accept.
3. With DEPTH=6 (ADDR_W=3), write addr 7 data 8'hFF, then read addr 7 -> both responses have rsp_err=1, rsp_rdata=0; dump unchanged.
4. Issue a read of addr 1 with rsp_ready=0 for 3 cycles -> rsp_valid stays 1 with rsp_rdata=8'h06; req_ready=0 throughout; a second queued request is accepted on the edge rsp_ready rises.
5. Stream 8 back-to-back reads of addr 0..7 with rsp_ready=1 -> 8 consecutive rsp_valid cycles, data matching dump order.
6. Assert rst_n low mid-stream, with a response pending -> rsp_valid=0 immediately; after release, the clear runs again and dump returns to 64'h0006000000000000. With DM_SOFT_CLEAR_EN, repeat the recovery via soft_clr and check the same dump.
